// File: rtl/serial_pkg.sv
// Shared definitions for the serial TX/RX side controllers:
// arbiter state encoding and the default end-of-message byte.
package serial_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam logic [7:0] EOM_DEFAULT = 8'h0A;

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index searching upward
// from last+1 with wrap-around, plus an any-request flag.
module rr_pick #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [IDX_W-1:0]     o_grant,
    output logic                 o_any
);

    int w_idx;

    // Offset NUM_PORTS wraps back to last itself, so it is checked last.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = (int'(i_last) + k) % NUM_PORTS;
            if (!o_any && i_req[IDX_W'(w_idx)]) begin
                o_any   = 1'b1;
                o_grant = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial TX among NUM_PORTS requesters with message-level locking
// and round-robin grants; releases on EOM, burst limit or owner idle timeout.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter  int                  NUM_PORTS = 4,
    parameter  int                  MAX_BITS  = 8,
    parameter  logic [MAX_BITS-1:0] EOM       = MAX_BITS'(EOM_DEFAULT),
    parameter  int                  MAX_BURST = 64,
    parameter  int                  TIMEOUT   = 16,
    localparam int                  OWN_W     = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*MAX_BITS-1:0] req_data,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [MAX_BITS-1:0]           tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [OWN_W-1:0]              owner,
    output logic                          busy
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [OWN_W-1:0]    r_owner;
    logic [OWN_W-1:0]    r_last;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;

    logic [OWN_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic                w_owner_valid;
    logic [MAX_BITS-1:0] w_owner_data;
    logic                w_beat;
    logic                w_eom_hit;
    logic                w_burst_hit;
    logic                w_timeout_hit;
    logic                w_release;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_data  = req_data[int'(r_owner)*MAX_BITS +: MAX_BITS];

    // Pass-through of the locked owner; nothing leaves the block while IDLE.
    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        busy      = 1'b0;
        if (r_state == ST_LOCKED) begin
            busy               = 1'b1;
            tx_data            = w_owner_data;
            tx_valid           = w_owner_valid;
            req_ready[r_owner] = tx_ready;
        end
    end

    assign owner = r_owner;

    assign w_beat        = tx_valid && tx_ready;
    assign w_eom_hit     = w_beat && (tx_data == EOM);
    assign w_burst_hit   = w_beat && (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
    assign w_timeout_hit = (TIMEOUT != 0) && !w_owner_valid &&
                           (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign w_release     = (r_state == ST_LOCKED) &&
                           (w_eom_hit || w_burst_hit || w_timeout_hit);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_pick_any) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_release)  w_state_next = ST_IDLE;
        endcase
    end

    // Counters only move while LOCKED and are cleared by each new grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_last     <= OWN_W'(NUM_PORTS - 1);
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_owner    <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_release) r_last <= r_owner;
                    if (w_beat && r_beat_cnt != BEAT_W'(MAX_BURST))
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                    if (w_owner_valid)
                        r_idle_cnt <= '0;
                    else if (r_idle_cnt != IDLE_W'(TIMEOUT))
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: a message-level reference model
// predicts grants/releases while per-port queues check every delivered byte.
module tb_serial_tx_arbiter;

    localparam int NP    = 4;
    localparam int MB    = 8;
    localparam int IW    = $clog2(NP);
    localparam int BURST = 4;
    localparam int TMO   = 16;
    localparam int EOMV  = 'h0A;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NP*MB-1:0]    req_data;
    logic [NP-1:0]       req_valid;
    logic [NP-1:0]       req_ready;
    logic [MB-1:0]       tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [IW-1:0]       owner;
    logic                busy;

    // Items >= 0 are bytes; a negative item -n holds valid low for n cycles.
    int sendQ[NP][$];
    int expQ[NP][$];
    int stallCnt[NP];
    int acceptedCnt[NP];
    int grantLog[$];
    bit gapMode;
    bit readyMode;
    int checks = 0;
    int failures = 0;

    bit mBusy;
    int mOwner;
    int mLast;
    int mBeats;
    int mIdle;

    always #5 clk = ~clk;

    serial_tx_arbiter #(
        .NUM_PORTS (NP),
        .MAX_BITS  (MB),
        .MAX_BURST (BURST),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .owner     (owner),
        .busy      (busy)
    );

    task automatic checkEq(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkStr(input string name, input string actual, input string expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got '%s', expected '%s'", name, actual, expected);
        end
    endtask

    function automatic bit bitAt(input logic [NP-1:0] v, input int i);
        return v[i[IW-1:0]];
    endfunction

    function automatic int rrPick(input logic [NP-1:0] reqs, input int last);
        for (int k = 1; k <= NP; k++)
            if (bitAt(reqs, (last + k) % NP)) return (last + k) % NP;
        return -1;
    endfunction

    function automatic string grantsStr();
        string s = "";
        foreach (grantLog[i])
            s = (i == 0) ? $sformatf("%0d", grantLog[i]) : $sformatf("%s,%0d", s, grantLog[i]);
        return s;
    endfunction

    // Expected outputs for the current cycle, then the model steps to the next edge.
    task automatic checkOutput();
        logic [NP-1:0] expReady;
        bit expValid, beat, rel;
        int expByte;
        expValid = mBusy && bitAt(req_valid, mOwner);
        expReady = '0;
        if (mBusy && tx_ready) expReady[mOwner[IW-1:0]] = 1'b1;
        checkEq("busy", int'(busy), int'(mBusy));
        checkEq("owner", int'(owner), mOwner);
        checkEq("tx_valid", int'(tx_valid), int'(expValid));
        checkEq("req_ready", int'(req_ready), int'(expReady));
        beat = expValid && tx_ready;
        expByte = -1;
        if (beat) begin
            if (expQ[mOwner].size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL tx_data: beat on port %0d got %0h, expected no beat", mOwner, tx_data);
            end else begin
                expByte = expQ[mOwner].pop_front();
                checkEq("tx_data", int'(tx_data), expByte);
            end
        end
        if (!mBusy) begin
            if (req_valid != '0) begin
                mOwner = rrPick(req_valid, mLast);
                mBusy  = 1'b1;
                mBeats = 0;
                mIdle  = 0;
                grantLog.push_back(mOwner);
            end
        end else begin
            rel = 1'b0;
            if (beat) begin
                mBeats++;
                if (expByte == EOMV || mBeats == BURST) rel = 1'b1;
            end
            if (bitAt(req_valid, mOwner)) mIdle = 0;
            else begin
                mIdle++;
                if (TMO != 0 && mIdle >= TMO) rel = 1'b1;
            end
            if (rel) begin
                mBusy = 1'b0;
                mLast = mOwner;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mBusy  = 1'b0;
                mOwner = 0;
                mLast  = NP - 1;
                mBeats = 0;
                mIdle  = 0;
            end else begin
                checkOutput();
            end
        end
    end

    // One cycle of every port's producer: retire accepted beats, then present the next item.
    task automatic applyStimulus();
        logic [NP-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p[IW-1:0]]) begin
                void'(sendQ[p].pop_front());
                acceptedCnt[p]++;
                req_valid[p[IW-1:0]] = 1'b0;
            end
            if (!req_valid[p[IW-1:0]]) begin
                if (stallCnt[p] > 0) begin
                    stallCnt[p]--;
                end else if (sendQ[p].size() > 0 && sendQ[p][0] < 0) begin
                    stallCnt[p] = -sendQ[p][0] - 1;
                    void'(sendQ[p].pop_front());
                end else if (sendQ[p].size() > 0 && !(gapMode && $urandom_range(0, 3) == 0)) begin
                    req_valid[p[IW-1:0]] = 1'b1;
                    req_data[p*MB +: MB] = MB'(sendQ[p][0]);
                    expQ[p].push_back(sendQ[p][0]);
                end
            end
        end
        tx_ready = readyMode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    function automatic bit phaseDone();
        bit done = (req_valid == '0) && !busy && !mBusy;
        for (int p = 0; p < NP; p++)
            if (sendQ[p].size() != 0 || expQ[p].size() != 0) done = 1'b0;
        return done;
    endfunction

    task automatic runUntilIdle(input string name, input int budget, output int cycles);
        cycles = 0;
        do begin
            applyStimulus();
            cycles++;
        end while (!phaseDone() && cycles < budget);
        checkEq({name, "_completed"}, int'(phaseDone()), 1);
    endtask

    task automatic pushMsg(input int p, input int b0, input int b1);
        sendQ[p].push_back(b0);
        sendQ[p].push_back(b1);
        sendQ[p].push_back(EOMV);
    endtask

    initial begin
        int cyc;
        int len;
        int b;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        gapMode   = 1'b0;
        readyMode = 1'b0;
        for (int p = 0; p < NP; p++) begin
            stallCnt[p]    = 0;
            acceptedCnt[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Ports 0, 1, 3 contend from reset: strict rotation, whole messages.
        grantLog.delete();
        for (int p = 0; p < NP; p++) begin
            if (p == 2) continue;
            pushMsg(p, 'h10 + 4*p, 'h11 + 4*p);
            pushMsg(p, 'h12 + 4*p, 'h13 + 4*p);
        end
        runUntilIdle("contention", 400, cyc);
        checkStr("contention_order", grantsStr(), "0,1,3,0,1,3");

        // Lone port 2: one cycle to present, one to grant, three back-to-back beats.
        grantLog.delete();
        pushMsg(2, 'h41, 'h42);
        runUntilIdle("single", 100, cyc);
        checkEq("single_cycles", cyc, 5);
        checkStr("single_order", grantsStr(), "2");

        // Port 1 streams 10 bytes with no EOM; port 0 joins after 3 cycles.
        grantLog.delete();
        sendQ[0].push_back(-3);
        pushMsg(0, 'h61, 'h62);
        for (int i = 0; i < 10; i++) sendQ[1].push_back('h70 + i);
        runUntilIdle("burst", 300, cyc);
        checkStr("burst_order", grantsStr(), "1,0,1,1");

        // A 15-cycle stall keeps the lock; a 16-cycle stall releases it.
        grantLog.delete();
        readyMode = 1'b1;
        sendQ[1].push_back('h31);
        sendQ[1].push_back(-15);
        sendQ[1].push_back('h32);
        sendQ[1].push_back(-16);
        pushMsg(1, 'h33, 'h34);
        runUntilIdle("timeout", 300, cyc);
        checkStr("timeout_order", grantsStr(), "1,1");

        // Random traffic on every port with gaps and tx_ready backpressure.
        gapMode = 1'b1;
        for (int m = 0; m < 3; m++) begin
            for (int p = 0; p < NP; p++) begin
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) begin
                    b = $urandom_range(0, 255);
                    if (b == EOMV) b = 'h0B;
                    sendQ[p].push_back(b);
                end
                sendQ[p].push_back(EOMV);
            end
        end
        runUntilIdle("random", 3000, cyc);

        // Reset after two of five beats; port 0 must win the next arbitration.
        gapMode   = 1'b0;
        readyMode = 1'b0;
        acceptedCnt[2] = 0;
        sendQ[2].push_back('h51);
        sendQ[2].push_back('h52);
        pushMsg(2, 'h53, 'h54);
        cyc = 0;
        while (acceptedCnt[2] < 2 && cyc < 50) begin
            applyStimulus();
            cyc++;
        end
        checkEq("reset_prep_beats", acceptedCnt[2], 2);
        rst_n = 1'b0;
        req_valid = '0;
        for (int p = 0; p < NP; p++) begin
            sendQ[p].delete();
            expQ[p].delete();
            stallCnt[p] = 0;
        end
        grantLog.delete();
        pushMsg(3, 'h35, 'h36);
        pushMsg(0, 'h15, 'h16);
        applyStimulus();
        rst_n = 1'b1;
        #3;
        checkEq("reset_busy", int'(busy), 0);
        checkEq("reset_tx_valid", int'(tx_valid), 0);
        checkEq("reset_owner", int'(owner), 0);
        runUntilIdle("after_reset", 100, cyc);
        checkStr("after_reset_order", grantsStr(), "0,3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares one `cxxrtl_serial_tx` instance among `NUM_PORTS` requesters with message-level locking. A granted requester keeps exclusive use of the transmitter until it sends an end-of-message byte, hits a burst limit, or goes idle too long. Grants rotate round-robin so no port starves. The block sits between on-chip byte producers (debug console, monitor, loader) and the simulated serial TX blackbox.

## Interface
- `NUM_PORTS`, 4: number of requesters; must be ≥ 2.
- `MAX_BITS`, 8: beat width; must match the serial TX `MAX_BITS`.
- `EOM`, 8'h0A: end-of-message value, compared over the low `MAX_BITS` bits.
- `MAX_BURST`, 64: maximum beats per grant; must be ≥ 1.
- `TIMEOUT`, 16: number of consecutive owner-idle cycles that forces release; 0 disables the timeout.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_data`  in  NUM_PORTS*MAX_BITS  per-port beat; port i occupies bits [i*MAX_BITS +: MAX_BITS].
- `req_valid`  in  NUM_PORTS  per-port valid.
- `req_ready`  out  NUM_PORTS  per-port ready; at most one bit is high.
- `tx_data`  out  MAX_BITS  connects to serial TX `data`.
- `tx_valid`  out  1  connects to serial TX `valid`.
- `tx_ready`  in  1  connects to serial TX `ready`.
- `owner`  out  $clog2(NUM_PORTS)  index of the current or most recent grantee.
- `busy`  out  1  high while in LOCKED.

## Operation
- Two states: IDLE and LOCKED. Reset values: state IDLE, `owner` 0, round-robin pointer `last` = NUM_PORTS-1 (so port 0 wins first), beat counter 0, idle counter 0.
- In IDLE, `tx_valid`, all `req_ready` bits and `busy` are 0. No beat is ever passed through in IDLE.
- IDLE → LOCKED: when any `req_valid` bit is high, pick the first set bit searching upward from `last`+1 with wrap-around. Register it into `owner`. Clear both counters.
- In LOCKED, the owner's port is passed through combinationally:
  - `tx_data` = owner's `req_data`.
  - `tx_valid` = owner's `req_valid`.
  - `req_ready[owner]` = `tx_ready`; every other `req_ready` bit is 0.
- A beat is `tx_valid & tx_ready`. Each beat increments the beat counter, which is $clog2(MAX_BURST+1) bits wide and never wraps.
- LOCKED → IDLE (release) occurs on any of these conditions. On release, `last` ← `owner`.
  - A beat whose data equals `EOM`.
  - A beat that is the MAX_BURST-th of the grant.
  - `TIMEOUT` ≠ 0 and the owner's `req_valid` has been low for TIMEOUT consecutive cycles. The idle counter clears on any cycle where the owner's valid is high.
- If EOM, burst limit and timeout coincide in one cycle, there is a single release; the beat still completes.
- Non-owner `req_valid` activity in LOCKED has no effect; those requests wait.
- Requesters must hold `req_data` stable while `req_valid` is high and not yet accepted. The arbiter adds no buffering.

## Timing
- Arbitration latency: 1 cycle. A request seen at edge N is granted (LOCKED, `owner` updated) at edge N+1. The first beat can complete at edge N+2 at the earliest.
- Throughput in LOCKED: one beat per cycle, limited only by `tx_ready`.
- After a release, the block is in IDLE for exactly one cycle before any re-grant, so the gap between grants is at least 1 cycle.
- With `MAX_BURST` = 1, every beat releases; a continuously requesting port reaches at most one beat every 2 cycles when alone.
- Reset is synchronous. `rst_n` low at an edge forces IDLE and the reset values, dropping any in-flight message lock. `tx_valid` is 0 from that edge onward. A partially sent message is not resumed.
- `owner` holds its value through IDLE; it updates only on a grant and on reset.

## Structure
- Shared package `serial_pkg`: state encoding (IDLE/LOCKED) and default `EOM` constant, reused by future serial RX side controllers.
- One natural sub-module: `rr_pick`, a combinational round-robin picker. Inputs are a request vector and a `last` pointer; outputs are the grant index and an any-request flag.
- The rest is a single always block for state and counters plus a combinational pass-through mux.

## Test plan
- Single port: port 2 sends 8'h41, 8'h42, 8'h0A with `tx_ready` held high. Expected: grant 1 cycle after the first valid, 3 consecutive beats, release on 8'h0A, `last` = 2.
- Contention: ports 0, 1 and 3 all valid from reset, each sending 2 bytes + EOM. Expected: grant order 0, 1, 3, 0…; no interleaving of bytes within a message.
- Burst limit: `MAX_BURST` = 4, port 1 streams 10 bytes with no EOM while port 0 also requests. Expected: release after beat 4, port 0 granted next.
- Backpressure and timeout: `TIMEOUT` = 16, owner stalls `req_valid` for 15 cycles and then resumes, so the lock is held. Owner then stalls for 16 cycles, so release happens at the 16th idle edge. `tx_ready` toggling never drops or duplicates a beat.
- Reset mid-message: assert `rst_n` low for 1 cycle after 2 of 5 beats. Expected: `busy` = 0, `tx_valid` = 0, `owner` = 0 next cycle, and port 0 has priority on re-arbitration.
